// File: rtl/turbo_pkg.sv
// Shared constants and helpers for the turbo encoder / hard-decision decoder pair.
package turbo_pkg;
    localparam int         BLOCK_LEN = 8;
    localparam logic [3:0] G1        = 4'b1011;
    localparam logic [3:0] G2        = 4'b1101;
    localparam int         IL_A      = 5;
    localparam int         IL_B      = 3;
    localparam int         IDX_W     = $clog2(BLOCK_LEN);
    localparam int         ERR_W     = $clog2(BLOCK_LEN + 1);

    typedef enum logic [1:0] {COLLECT, CHECK, EMIT} state_t;

    typedef struct packed {
        logic p2;
        logic p1;
        logic sys;
    } sym_t;

    function automatic logic rsc_parity(input logic [3:0] w, input logic [3:0] g);
        return ^(w & g);
    endfunction
endpackage

// File: rtl/turbo_interleaver_idx.sv
// Block interleaver address: PI(k) = (IL_A*k + IL_B) mod BLOCK_LEN.
module turbo_interleaver_idx
    import turbo_pkg::*;
(
    input  logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] pi
);
    // BLOCK_LEN is a power of two, so the modulo is plain truncation.
    assign pi = IDX_W'(IL_A) * k + IDX_W'(IL_B);
endmodule

// File: rtl/turbo_hard_decoder.sv
// Hard-decision turbo receiver: buffers a block, re-encodes the systematic bits to
// count parity mismatches per constituent encoder, then streams the bits out.
module turbo_hard_decoder
    import turbo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             stat_valid,
    output logic [ERR_W-1:0] err1,
    output logic [ERR_W-1:0] err2,
    output logic             block_ok
);
    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_inc, pi_k;
    sym_t             sym_buf [BLOCK_LEN];
    logic             ready_q;
    logic [2:0]       r1, r2;
    logic [3:0]       w1, w2;
    logic [ERR_W-1:0] acc1, acc2, acc1_nxt, acc2_nxt;
    logic             sym_fire, bit_fire, last;

    assign last      = (idx == IDX_W'(BLOCK_LEN - 1));
    assign idx_inc   = last ? '0 : idx + IDX_W'(1);
    assign sym_ready = ready_q;
    assign sym_fire  = sym_valid && ready_q;
    assign bit_fire  = bit_valid && bit_ready;

    turbo_interleaver_idx u_il (.k(idx), .pi(pi_k));

    always_comb begin
        w1       = {r1, sym_buf[idx].sys};
        w2       = {r2, sym_buf[pi_k].sys};
        acc1_nxt = acc1;
        acc2_nxt = acc2;
        // Counters stop at BLOCK_LEN; every step mismatching is a legal outcome.
        if (rsc_parity(w1, G1) != sym_buf[idx].p1 && acc1 != ERR_W'(BLOCK_LEN))
            acc1_nxt = acc1 + ERR_W'(1);
        if (rsc_parity(w2, G2) != sym_buf[idx].p2 && acc2 != ERR_W'(BLOCK_LEN))
            acc2_nxt = acc2 + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (sym_fire && last) state_nxt = CHECK;
            CHECK:   if (last)             state_nxt = EMIT;
            EMIT:    if (bit_fire && last) state_nxt = COLLECT;
            default:                       state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        bit_valid = (state == EMIT);
        bit_out   = bit_valid ? sym_buf[idx].sys : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (sym_fire) sym_buf[idx] <= sym_t'(sym_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            ready_q    <= 1'b0;
            r1         <= '0;
            r2         <= '0;
            acc1       <= '0;
            acc2       <= '0;
            err1       <= '0;
            err2       <= '0;
            block_ok   <= 1'b0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            // Registered so ready stays low for the first cycle out of reset.
            ready_q    <= (state_nxt == COLLECT);
            case (state)
                COLLECT: begin
                    r1   <= '0;
                    r2   <= '0;
                    acc1 <= '0;
                    acc2 <= '0;
                    if (sym_fire) idx <= idx_inc;
                end
                CHECK: begin
                    r1   <= w1[2:0];
                    r2   <= w2[2:0];
                    acc1 <= acc1_nxt;
                    acc2 <= acc2_nxt;
                    idx  <= idx_inc;
                    if (last) begin
                        err1       <= acc1_nxt;
                        err2       <= acc2_nxt;
                        block_ok   <= (acc1_nxt == '0) && (acc2_nxt == '0);
                        stat_valid <= 1'b1;
                    end
                end
                EMIT: if (bit_fire) idx <= idx_inc;
                default: idx <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_turbo_hard_decoder.sv
// Directed-vector scoreboard bench for turbo_hard_decoder (BLOCK_LEN=8 defaults).
module tb_turbo_hard_decoder;
    import turbo_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       sym_in = '0;
    logic             sym_valid = 1'b0;
    logic             sym_ready;
    logic             bit_out, bit_valid;
    logic             bit_ready = 1'b1;
    logic             stat_valid;
    logic [ERR_W-1:0] err1, err2;
    logic             block_ok;

    turbo_hard_decoder dut (
        .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .stat_valid(stat_valid), .err1(err1), .err2(err2),
        .block_ok(block_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] e1;
        logic [3:0] e2;
        logic       ok;
    } stat_exp_t;

    stat_exp_t       stat_q[$];
    logic            bit_q[$];
    stat_exp_t       mon_e;
    logic            mon_b;
    int              checks = 0;
    int              errors = 0;
    int              bits_seen = 0;
    logic [0:7][2:0] cur_blk;
    // Symbols {p2,p1,sys}, k=0 first.
    logic [0:7][2:0] v_zero, v_imp, v_p1err, v_p2inv, v_mix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (stat_valid) begin
                if (stat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stat_unexpected: got stat_valid expected none");
                end else begin
                    mon_e = stat_q.pop_front();
                    check("err1", 32'(err1), 32'(mon_e.e1));
                    check("err2", 32'(err2), 32'(mon_e.e2));
                    check("block_ok", 32'(block_ok), 32'(mon_e.ok));
                end
                bits_seen = 0;
            end
            if (bit_valid && bit_ready) begin
                if (bit_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bit_unexpected: got bit %0b expected none", bit_out);
                end else begin
                    mon_b = bit_q.pop_front();
                    check("bit_out", 32'(bit_out), 32'(mon_b));
                end
                bits_seen++;
            end
        end
    end

    task automatic send_sym(input logic [2:0] s);
        int n = 0;
        @(negedge clk);
        sym_in    = s;
        sym_valid = 1'b1;
        while (!sym_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) begin
            checks++; errors++;
            $display("FAIL sym_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_block(input logic [0:7][2:0] blk, input int e1, input int e2);
        cur_blk = blk;
        stat_q.push_back('{4'(e1), 4'(e2), (e1 == 0 && e2 == 0)});
        for (int k = 0; k < 8; k++) bit_q.push_back(blk[k][0]);
        for (int k = 0; k < 8; k++) send_sym(blk[k]);
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (stat_q.size() == 0 && bit_q.size() == 0) return;
            @(negedge clk);
            #2;
        end
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", stat_q.size() + bit_q.size());
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sym_ready"},  32'(sym_ready),  32'd0);
        check({tag, "_bit_valid"},  32'(bit_valid),  32'd0);
        check({tag, "_bit_out"},    32'(bit_out),    32'd0);
        check({tag, "_stat_valid"}, 32'(stat_valid), 32'd0);
        check({tag, "_err1"},       32'(err1),       32'd0);
        check({tag, "_err2"},       32'(err2),       32'd0);
        check({tag, "_block_ok"},   32'(block_ok),   32'd0);
    endtask

    initial begin
        v_zero  = {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        v_imp   = {3'b011, 3'b110, 3'b000, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000};
        v_p1err = {3'b011, 3'b110, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        v_p2inv = {3'b111, 3'b010, 3'b100, 3'b010, 3'b000, 3'b100, 3'b100, 3'b100};
        // u=1,1,0,1,0,0,1,0 with zero parity: pe1 has 3 ones, pe2 has 6 ones.
        v_mix   = {3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000};

        repeat (3) @(negedge clk);
        #2;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("ready_after_reset", 32'(sym_ready), 32'd1);

        send_block(v_zero, 0, 0);
        wait_drain();
        send_block(v_imp, 0, 0);
        wait_drain();
        send_block(v_p1err, 1, 0);
        wait_drain();
        send_block(v_p2inv, 0, 8);
        wait_drain();

        // Stall mid-EMIT: held bit must match the next unaccepted bit of the block.
        send_block(v_mix, 3, 6);
        for (int i = 0; i < 100 && stat_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        @(negedge clk);
        bit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("stall_bit_valid", 32'(bit_valid), 32'd1);
            check("stall_bit_out",   32'(bit_out),   32'(cur_blk[bits_seen][0]));
            check("stall_sym_ready", 32'(sym_ready), 32'd0);
        end
        @(negedge clk);
        bit_ready = 1'b1;
        wait_drain();

        // Abort a half-sent block with reset, then send a clean one.
        for (int k = 0; k < 4; k++) send_sym(v_p1err[k]);
        @(negedge clk);
        sym_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        #2;
        check_idle_outputs("midreset");
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("ready_after_midreset", 32'(sym_ready), 32'd1);
        send_block(v_imp, 0, 0);
        wait_drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
